// File: rtl/pcie_legacyint_pkg.sv
// Shared definitions for the PCIe legacy-interrupt path: INTx state encoding,
// message code bases and the message-controller FSM enum.
package pcie_legacyint_pkg;

  typedef logic [1:0] intx_state_t;

  localparam intx_state_t ST_IDLE        = 2'b00;
  localparam intx_state_t ST_ASSERTING   = 2'b01;
  localparam intx_state_t ST_ASSERTED    = 2'b10;
  localparam intx_state_t ST_DEASSERTING = 2'b11;

  localparam logic [7:0] MSG_ASSERT_INTA   = 8'h20;
  localparam logic [7:0] MSG_DEASSERT_INTA = 8'h24;

  typedef enum logic [0:0] {
    C_IDLE = 1'b0,
    C_REQ  = 1'b1
  } ctrl_st_e;

  // Assert_INTx / Deassert_INTx codes are the INTA base plus the pin index.
  function automatic logic [7:0] intx_msg_code(input logic       assert_level,
                                               input logic [1:0] pin);
    logic [7:0] base;
    base = assert_level ? MSG_ASSERT_INTA : MSG_DEASSERT_INTA;
    return base + {6'b000000, pin};
  endfunction

endpackage

// File: rtl/pcie_legacyint_msg_ctrl_if.sv
// Message handshake between the legacy-INT controller (master) and the TLP
// message generator (slave).
interface pcie_legacyint_msg_ctrl_if;

  logic       msg_req;
  logic [7:0] msg_code;
  logic       msg_ack;

  modport master (
    output msg_req,
    output msg_code,
    input  msg_ack
  );

  modport slave (
    input  msg_req,
    input  msg_code,
    output msg_ack
  );

endinterface

// File: rtl/pcie_legacyint_ack_timer.sv
// Acknowledge watchdog: counts cycles while run_i is high, clears when it is
// low, flags expiry at TIMEOUT-1. Only built with PCIE_LEGACYINT_TIMEOUT_EN.
module pcie_legacyint_ack_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;
  localparam logic [TimerW-1:0] LastCnt = TimerW'(TIMEOUT - 1);

  logic [TimerW-1:0] cnt_q, cnt_d;

  assign expired_o = run_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcie_legacyint_msg_ctrl.sv
// Legacy INTx state register and Assert/Deassert_INTx message handshake.
// Optional ack timeout enabled by defining PCIE_LEGACYINT_TIMEOUT_EN.
module pcie_legacyint_msg_ctrl
  import pcie_legacyint_pkg::*;
#(
  parameter int unsigned INTX_PIN = 0,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  output logic [1:0]                         state_o,
  input  logic [1:0]                         next_state_i,
  input  logic                               next_state_en_i,
  input  logic                               interrupt_assert_i,
  input  logic                               intx_disable_i,
  output logic                               line_asserted_o,
  output logic                               busy_o,
  pcie_legacyint_msg_ctrl_if.master          msg_io,
  output logic                               timeout_o
);

  if ((INTX_PIN > 3) || (TIMEOUT < 2)) begin : g_param_check
    $error("pcie_legacyint_msg_ctrl: INTX_PIN must be 0..3 and TIMEOUT >= 2");
  end

  localparam logic [1:0] PinIdx = 2'(INTX_PIN);

  ctrl_st_e    ctrl_q;
  intx_state_t state_q;
  intx_state_t tgt_state_q;
  logic        line_q;
  logic        tgt_level_q;
  logic [7:0]  code_q;
  logic        timeout_q;
  logic        timer_expired;

`ifdef PCIE_LEGACYINT_TIMEOUT_EN
  pcie_legacyint_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .run_i     (ctrl_q == C_REQ),
    .expired_o (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ctrl_q      <= C_IDLE;
      state_q     <= ST_IDLE;
      tgt_state_q <= ST_IDLE;
      line_q      <= 1'b0;
      tgt_level_q <= 1'b0;
      code_q      <= 8'h00;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (ctrl_q)
        C_IDLE: begin
          if (intx_disable_i && line_q) begin
            // Interrupt Disable forces the wire low regardless of next-state logic.
            ctrl_q      <= C_REQ;
            tgt_state_q <= ST_IDLE;
            tgt_level_q <= 1'b0;
            code_q      <= intx_msg_code(1'b0, PinIdx);
          end else if (next_state_en_i) begin
            if (interrupt_assert_i == line_q) begin
              state_q <= next_state_i;
            end else if (!(interrupt_assert_i && intx_disable_i)) begin
              ctrl_q      <= C_REQ;
              tgt_state_q <= next_state_i;
              tgt_level_q <= interrupt_assert_i;
              code_q      <= intx_msg_code(interrupt_assert_i, PinIdx);
            end
          end
        end
        C_REQ: begin
          if (msg_io.msg_ack) begin
            ctrl_q  <= C_IDLE;
            state_q <= tgt_state_q;
            line_q  <= tgt_level_q;
          end else if (timer_expired) begin
            // Abort leaves state untouched; the next evaluation retries.
            ctrl_q    <= C_IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: ctrl_q <= C_IDLE;
      endcase
    end
  end

  assign state_o         = state_q;
  assign line_asserted_o = line_q;
  assign busy_o          = (ctrl_q == C_REQ);
  assign msg_io.msg_req  = (ctrl_q == C_REQ);
  assign msg_io.msg_code = code_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_pcie_legacyint_msg_ctrl.sv
// Directed bench for pcie_legacyint_msg_ctrl (INTX_PIN=2, TIMEOUT=16).
module tb_pcie_legacyint_msg_ctrl;

  localparam int unsigned IntxPin = 2;
  localparam int unsigned Timeout = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  logic [1:0] next_state;
  logic       next_state_en;
  logic       interrupt_assert;
  logic       intx_disable;
  logic       line_asserted;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  pcie_legacyint_msg_ctrl_if msg_if ();

  pcie_legacyint_msg_ctrl #(
    .INTX_PIN (IntxPin),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .state_o            (state),
    .next_state_i       (next_state),
    .next_state_en_i    (next_state_en),
    .interrupt_assert_i (interrupt_assert),
    .intx_disable_i     (intx_disable),
    .line_asserted_o    (line_asserted),
    .busy_o             (busy),
    .msg_io             (msg_if.master),
    .timeout_o          (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic line,
                            input logic req);
    check({tag, ".state"}, {6'b0, state}, {6'b0, st});
    check({tag, ".line"}, {7'b0, line_asserted}, {7'b0, line});
    check({tag, ".req"}, {7'b0, msg_if.msg_req}, {7'b0, req});
  endtask

  initial begin
    rst_n            = 1'b0;
    next_state       = 2'b00;
    next_state_en    = 1'b0;
    interrupt_assert = 1'b0;
    intx_disable     = 1'b0;
    msg_if.msg_ack   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Reset / idle
    check_outs("reset", 2'b00, 1'b0, 1'b0);
    check("reset.busy", {7'b0, busy}, 8'h00);
    check("reset.code", msg_if.msg_code, 8'h00);
    check("reset.timeout", {7'b0, timeout}, 8'h00);

    // Same-level load: one-cycle latency, no message
    next_state = 2'b01; interrupt_assert = 1'b0; next_state_en = 1'b1;
    tick();
    next_state_en = 1'b0;
    check_outs("load", 2'b01, 1'b0, 1'b0);

    // Assert message, code 0x20+2, ack in third request cycle
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    check_outs("asrt.launch", 2'b01, 1'b0, 1'b1);
    check("asrt.code", msg_if.msg_code, 8'h22);
    check("asrt.busy", {7'b0, busy}, 8'h01);
    // Inputs that would load in idle must be ignored while busy
    next_state = 2'b11; interrupt_assert = 1'b0; next_state_en = 1'b1;
    tick();
    tick();
    check_outs("asrt.wait", 2'b01, 1'b0, 1'b1);
    check("asrt.code_hold", msg_if.msg_code, 8'h22);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0; next_state_en = 1'b0;
    check_outs("asrt.done", 2'b10, 1'b1, 1'b0);

    // Stray ack while idle
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("stray_ack", 2'b10, 1'b1, 1'b0);

    // Interrupt Disable with line high -> Deassert, code 0x24+2, 2-cycle round trip
    intx_disable = 1'b1;
    tick();
    check_outs("dis.launch", 2'b10, 1'b1, 1'b1);
    check("dis.code", msg_if.msg_code, 8'h26);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("dis.done", 2'b00, 1'b0, 1'b0);

    // Disabled: assert request dropped, same-level load still accepted
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    check_outs("dis.drop", 2'b00, 1'b0, 1'b0);
    next_state = 2'b01; interrupt_assert = 1'b0;
    tick();
    next_state_en = 1'b0; intx_disable = 1'b0;
    check_outs("dis.load", 2'b01, 1'b0, 1'b0);

    // Back-to-back: relaunch in the cycle after completion
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    next_state = 2'b11; interrupt_assert = 1'b0; msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("b2b.first", 2'b10, 1'b1, 1'b0);
    tick();
    next_state_en = 1'b0;
    check_outs("b2b.second", 2'b10, 1'b1, 1'b1);
    check("b2b.code", msg_if.msg_code, 8'h26);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("b2b.done", 2'b11, 1'b0, 1'b0);

    // Disable rising mid-request is deferred until back in idle
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    next_state_en = 1'b0; intx_disable = 1'b1;
    tick();
    check("defer.code", msg_if.msg_code, 8'h22);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("defer.asrt", 2'b10, 1'b1, 1'b0);
    tick();
    check_outs("defer.deasrt", 2'b10, 1'b1, 1'b1);
    check("defer.code2", msg_if.msg_code, 8'h26);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0; intx_disable = 1'b0;
    check_outs("defer.done", 2'b00, 1'b0, 1'b0);

`ifdef PCIE_LEGACYINT_TIMEOUT_EN
    // No ack: abort after 16 request cycles, state unchanged
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    next_state_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check("to.pending", {6'b0, msg_if.msg_req, timeout}, 8'h02);
      tick();
    end
    check("to.last_req", {6'b0, msg_if.msg_req, timeout}, 8'h02);
    tick();
    check_outs("to.abort", 2'b00, 1'b0, 1'b0);
    check("to.pulse", {7'b0, timeout}, 8'h01);
    tick();
    check("to.pulse_end", {7'b0, timeout}, 8'h00);
    // Ack in the expiry cycle wins
    next_state_en = 1'b1;
    tick();
    next_state_en = 1'b0;
    repeat (15) tick();
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("to.ack_wins", 2'b10, 1'b1, 1'b0);
    check("to.no_pulse", {7'b0, timeout}, 8'h00);
`else
    // No timer: request waits well past TIMEOUT
    next_state = 2'b10; interrupt_assert = 1'b1; next_state_en = 1'b1;
    tick();
    next_state_en = 1'b0;
    repeat (40) tick();
    check_outs("notimer.wait", 2'b00, 1'b0, 1'b1);
    check("notimer.timeout", {7'b0, timeout}, 8'h00);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("notimer.done", 2'b10, 1'b1, 1'b0);
`endif

    // Reset mid-request, then a late ack is ignored
    intx_disable = 1'b1;
    tick();
    check_outs("rst.launch", 2'b10, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; intx_disable = 1'b0;
    check_outs("rst.during", 2'b00, 1'b0, 1'b0);
    check("rst.code", msg_if.msg_code, 8'h00);
    msg_if.msg_ack = 1'b1;
    tick();
    msg_if.msg_ack = 1'b0;
    check_outs("rst.late_ack", 2'b00, 1'b0, 1'b0);
    check("rst.busy", {7'b0, busy}, 8'h00);
    check("rst.timeout", {7'b0, timeout}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
